// File: rtl/led_pwm_fader_pkg.sv
// Shared types and defaults for the LED PWM fader.
// The channel state enum is used by led_pwm_channel; the default widths
// and ramp divider are used as parameter defaults by led_pwm_fader.
// Optional feature macro: LED_PWM_FADER_GAMMA_EN (see led_pwm_channel).
package led_pwm_fader_pkg;

    // Per-channel fade state
    typedef enum logic [1:0] {
        CH_OFF  = 2'd0,
        CH_RISE = 2'd1,
        CH_ON   = 2'd2,
        CH_FALL = 2'd3
    } ch_state_e;

    localparam int DEF_N_LEDS   = 4;
    localparam int DEF_PWM_BITS = 8;
    localparam int DEF_RAMP_DIV = 16384;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: fade state machine, brightness level, duty mapping and
// registered PWM compare against the shared free-running PWM counter.
// Build option LED_PWM_FADER_GAMMA_EN selects a squared (gamma-like)
// duty curve; without it the duty is the level itself and no multiplier
// exists.
module led_pwm_channel
    import led_pwm_fader_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tgt_i,
    input  logic                ramp_tick_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    output logic                led_o,
    output logic                idle_o
);

    localparam logic [PWM_BITS-1:0] LVL_MAX = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] LVL_MIN = '0;

    ch_state_e           state_q, state_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS-1:0] duty;
    logic                led_q, led_d;

    // Step up by one, holding at full brightness instead of wrapping
    function automatic logic [PWM_BITS-1:0] sat_inc(input logic [PWM_BITS-1:0] v);
        return (v == LVL_MAX) ? LVL_MAX : v + PWM_BITS'(1);
    endfunction

    // Step down by one, holding at dark instead of wrapping
    function automatic logic [PWM_BITS-1:0] sat_dec(input logic [PWM_BITS-1:0] v);
        return (v == LVL_MIN) ? LVL_MIN : v - PWM_BITS'(1);
    endfunction

`ifdef LED_PWM_FADER_GAMMA_EN
    // Squared brightness curve; full level forced to full duty so the top
    // step is a solid on rather than (MAX*MAX)>>PWM_BITS
    function automatic logic [PWM_BITS-1:0] gamma_duty(input logic [PWM_BITS-1:0] lvl);
        logic [2*PWM_BITS-1:0] sq;
        sq = {{PWM_BITS{1'b0}}, lvl} * {{PWM_BITS{1'b0}}, lvl};
        return (lvl == LVL_MAX) ? LVL_MAX : sq[2*PWM_BITS-1:PWM_BITS];
    endfunction
`endif

    // State, level and pad drive registers; reset lands every channel dark
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CH_OFF;
            level_q <= '0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            led_q   <= led_d;
        end
    end

    // Next state: a ramp tick always acts on the state held this cycle, so a
    // simultaneous target change only redirects the following ticks
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        case (state_q)
            CH_OFF: begin
                if (tgt_i) state_d = CH_RISE;
            end
            CH_RISE: begin
                if (ramp_tick_i) level_d = sat_inc(level_q);
                if (!tgt_i)                  state_d = CH_FALL;
                else if (level_d == LVL_MAX) state_d = CH_ON;
            end
            CH_ON: begin
                if (!tgt_i) state_d = CH_FALL;
            end
            CH_FALL: begin
                if (ramp_tick_i) level_d = sat_dec(level_q);
                if (tgt_i)                   state_d = CH_RISE;
                else if (level_d == LVL_MIN) state_d = CH_OFF;
            end
            default: begin
                state_d = CH_OFF;
                level_d = LVL_MIN;
            end
        endcase
    end

    // Outputs: duty mapping, PWM compare (solid at the extremes) and idle
    always_comb begin
`ifdef LED_PWM_FADER_GAMMA_EN
        duty = gamma_duty(level_q);
`else
        duty = level_q;
`endif
        if (duty == LVL_MIN)      led_d = 1'b0;
        else if (duty == LVL_MAX) led_d = 1'b1;
        else                      led_d = (duty > pwm_cnt_i);
        idle_o = ((state_q == CH_OFF) && !tgt_i) || ((state_q == CH_ON) && tgt_i);
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_pwm_fader.sv
// LED PWM fader top: registers the target pattern, runs the shared PWM and
// ramp counters, instantiates one led_pwm_channel per LED and reduces the
// per-channel idle flags into a registered idle output.
// Build option LED_PWM_FADER_GAMMA_EN enables the squared duty curve in
// every channel.
module led_pwm_fader
    import led_pwm_fader_pkg::*;
#(
    parameter int N_LEDS   = DEF_N_LEDS,
    parameter int PWM_BITS = DEF_PWM_BITS,
    parameter int RAMP_DIV = DEF_RAMP_DIV
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_LEDS-1:0] led_in,
    output logic [N_LEDS-1:0] led_out,
    output logic              idle
);

    localparam int                RAMP_W    = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);

    logic [N_LEDS-1:0]   tgt_q;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [RAMP_W-1:0]   ramp_cnt_q, ramp_cnt_d;
    logic                ramp_tick;
    logic [N_LEDS-1:0]   ch_led;
    logic [N_LEDS-1:0]   ch_idle;
    logic                idle_q, idle_d;

    // Counter next values and idle reduction across all channels
    always_comb begin
        ramp_tick  = (ramp_cnt_q == RAMP_LAST);
        ramp_cnt_d = ramp_tick ? '0 : ramp_cnt_q + RAMP_W'(1);
        pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
        idle_d     = &ch_idle;
    end

    // Target capture, shared counters and idle flag; idle reads 1 in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_q      <= '0;
            pwm_cnt_q  <= '0;
            ramp_cnt_q <= '0;
            idle_q     <= 1'b1;
        end else begin
            tgt_q      <= led_in;
            pwm_cnt_q  <= pwm_cnt_d;
            ramp_cnt_q <= ramp_cnt_d;
            idle_q     <= idle_d;
        end
    end

    for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
        led_pwm_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .tgt_i      (tgt_q[i]),
            .ramp_tick_i(ramp_tick),
            .pwm_cnt_i  (pwm_cnt_q),
            .led_o      (ch_led[i]),
            .idle_o     (ch_idle[i])
        );
    end

    assign led_out = ch_led;
    assign idle    = idle_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader (PWM_BITS=4, RAMP_DIV=2, N_LEDS=4).
// A behavioural reference model predicts led_out/idle on every clock edge
// and queues the prediction; a checker pops and compares on the falling
// edge. Directed steps add reset, fade timing, async reset and
// per-level duty checks on a standalone channel instance.
module tb_led_pwm_fader;

    localparam int NL   = 4;
    localparam int PB   = 4;
    localparam int MAXV = (1 << PB) - 1;
    localparam int RD   = 2;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic [NL-1:0] led_in = '0;
    logic [NL-1:0] led_out;
    logic          idle;

    logic          ch_tgt  = 1'b0;
    logic          ch_tick = 1'b0;
    logic [PB-1:0] tb_pwm  = '0;
    logic          ch_led;
    logic          ch_idle;

    int checks = 0;
    int errors = 0;

    logic [NL:0]   exp_q[$];
    logic [NL:0]   sb_exp;

    int            m_lvl[NL];
    int            m_st[NL];
    logic [NL-1:0] m_tgt;
    int            m_pwm;
    int            m_ramp;
    logic [NL-1:0] e_led;
    logic          e_idle;
    logic          tick_m;
    int            d_m;

    always #5 clk = ~clk;

    always @(posedge clk) tb_pwm <= tb_pwm + 4'd1;

    led_pwm_fader #(
        .N_LEDS  (NL),
        .PWM_BITS(PB),
        .RAMP_DIV(RD)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .led_in (led_in),
        .led_out(led_out),
        .idle   (idle)
    );

    led_pwm_channel #(
        .PWM_BITS(PB)
    ) u_chan (
        .clk        (clk),
        .rst_n      (rst_n),
        .tgt_i      (ch_tgt),
        .ramp_tick_i(ch_tick),
        .pwm_cnt_i  (tb_pwm),
        .led_o      (ch_led),
        .idle_o     (ch_idle)
    );

    function automatic int duty_of(input int l);
`ifdef LED_PWM_FADER_GAMMA_EN
        if (l == MAXV) return MAXV;
        return (l * l) >> PB;
`else
        return l;
`endif
    endfunction

    task automatic chk(input string tag, input int got, input int req);
        checks++;
        assert (got === req) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, req);
        end
    endtask

    task automatic chk_rng(input string tag, input int got, input int lo, input int hi);
        checks++;
        assert (got >= lo && got <= hi) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d..%0d", tag, got, lo, hi);
        end
    endtask

    task automatic ch_ticks(input int k);
        repeat (k) begin
            @(negedge clk); ch_tick = 1'b1;
            @(negedge clk); ch_tick = 1'b0;
        end
    endtask

    task automatic ch_count(output int n);
        n = 0;
        repeat (16) begin
            @(negedge clk);
            n += int'(ch_led);
        end
    endtask

    // Reference model: one step per rising edge, reset on rst_n low
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < NL; i++) begin
                    m_lvl[i] = 0;
                    m_st[i]  = 0;
                end
                m_tgt  = '0;
                m_pwm  = 0;
                m_ramp = 0;
                exp_q.delete();
                exp_q.push_back({{NL{1'b0}}, 1'b1});
            end else begin
                tick_m = (m_ramp == RD - 1);
                e_led  = '0;
                e_idle = 1'b1;
                for (int i = 0; i < NL; i++) begin
                    d_m = duty_of(m_lvl[i]);
                    if (d_m == 0)         e_led[i] = 1'b0;
                    else if (d_m == MAXV) e_led[i] = 1'b1;
                    else                  e_led[i] = (d_m > m_pwm);
                    if (!((m_st[i] == 0 && !m_tgt[i]) || (m_st[i] == 2 && m_tgt[i])))
                        e_idle = 1'b0;
                    case (m_st[i])
                        0: if (m_tgt[i]) m_st[i] = 1;
                        1: begin
                            if (tick_m && m_lvl[i] < MAXV) m_lvl[i]++;
                            if (!m_tgt[i])             m_st[i] = 3;
                            else if (m_lvl[i] == MAXV) m_st[i] = 2;
                        end
                        2: if (!m_tgt[i]) m_st[i] = 3;
                        3: begin
                            if (tick_m && m_lvl[i] > 0) m_lvl[i]--;
                            if (m_tgt[i])           m_st[i] = 1;
                            else if (m_lvl[i] == 0) m_st[i] = 0;
                        end
                        default: m_st[i] = 0;
                    endcase
                end
                m_tgt  = led_in;
                m_pwm  = (m_pwm + 1) % (MAXV + 1);
                m_ramp = (m_ramp + 1) % RD;
                exp_q.delete();
                exp_q.push_back({e_led, e_idle});
            end
        end
    end

    // Scoreboard checker on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                sb_exp = exp_q.pop_front();
                checks++;
                assert ({led_out, idle} === sb_exp) else begin
                    errors++;
                    $error("FAIL scoreboard t=%0t: got led_out=%b idle=%b expected led_out=%b idle=%b",
                           $time, led_out, idle, sb_exp[NL:1], sb_exp[0]);
                end
            end
        end
    end

    initial begin
        int n;

        // Reset and quiet run
        repeat (3) @(negedge clk);
        chk("reset_led_out", int'(led_out), 0);
        chk("reset_idle", int'(idle), 1);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("quiet_led_out", int'(led_out), 0);
        chk("quiet_idle", int'(idle), 1);

        // Fade up channel 0
        led_in = 4'b0001;
        repeat (2) @(negedge clk);
        chk("fade_idle_drop", int'(idle), 0);
        n = 0;
        while (idle === 1'b0 && n < 80) begin
            n++;
            @(negedge clk);
        end
        chk("fade_up_no_timeout", int'(n < 80), 1);
        chk_rng("fade_up_cycles", n, 28, 32);
        n = 0;
        repeat (16) begin
            @(negedge clk);
            n += int'(led_out[0] & idle);
        end
        chk("on_steady", n, 16);

        // Fall, reverse mid-fall, fall again
        led_in = 4'b0000;
        repeat (9) @(negedge clk);
        led_in = 4'b0001;
        repeat (6) @(negedge clk);
        led_in = 4'b0000;
        repeat (60) @(negedge clk);
        chk("reversal_settled_idle", int'(idle), 1);
        chk("reversal_settled_dark", int'(led_out), 0);

        // Reset in the middle of a fade
        led_in = 4'b1111;
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_led_out", int'(led_out), 0);
        chk("async_reset_idle", int'(idle), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            n += int'(led_out != '0);
        end
        chk("restart_from_zero", n, 0);
        repeat (40) @(negedge clk);

        // Random target patterns, model-checked every cycle
        for (int k = 0; k < 12; k++) begin
            led_in = 4'($urandom);
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end
        led_in = '0;
        repeat (3) @(negedge clk);
        n = 0;
        while (idle !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("random_final_idle", int'(idle), 1);
        chk("random_final_dark", int'(led_out), 0);

        // Standalone channel: duty per held level
        @(negedge clk); ch_tgt = 1'b1;
        @(negedge clk);
        chk("ch_rise_not_idle", int'(ch_idle), 0);
        ch_ticks(5);
        ch_count(n); chk("ch_duty_lvl5", n, duty_of(5));
        ch_ticks(3);
        ch_count(n); chk("ch_duty_lvl8", n, duty_of(8));
        ch_ticks(7);
        ch_count(n); chk("ch_duty_lvl15", n, 16);
        chk("ch_on_idle", int'(ch_idle), 1);
        ch_ticks(1);
        ch_count(n); chk("ch_on_saturate", n, 16);

        // Fall to dark, then rise and reverse at level 7
        ch_tgt = 1'b0;
        @(negedge clk);
        ch_ticks(16);
        ch_count(n); chk("ch_fall_dark", n, 0);
        chk("ch_off_idle", int'(ch_idle), 1);
        ch_tgt = 1'b1;
        @(negedge clk);
        ch_ticks(7);
        ch_count(n); chk("ch_duty_lvl7", n, duty_of(7));
        ch_tgt = 1'b0;
        ch_count(n); chk("ch_reverse_no_jump", n, duty_of(7));
        ch_ticks(1);
        ch_count(n); chk("ch_reverse_lvl6", n, duty_of(6));
        ch_ticks(5);
        ch_count(n); chk("ch_reverse_lvl1", n, duty_of(1));
        chk("ch_falling_not_idle", int'(ch_idle), 0);
        ch_ticks(1);
        ch_count(n); chk("ch_reverse_off", n, 0);
        chk("ch_reverse_off_idle", int'(ch_idle), 1);

        // Tick coinciding with a target change acts on the old state
        @(negedge clk); ch_tgt = 1'b1; ch_tick = 1'b1;
        @(negedge clk); ch_tick = 1'b0;
        ch_count(n); chk("ch_tick_in_off_ignored", n, 0);
        ch_ticks(2);
        @(negedge clk); ch_tgt = 1'b0; ch_tick = 1'b1;
        @(negedge clk); ch_tick = 1'b0;
        ch_count(n); chk("ch_tick_with_toggle", n, duty_of(3));
        ch_ticks(3);
        ch_count(n); chk("ch_toggle_settle_dark", n, 0);
        chk("ch_toggle_settle_idle", int'(ch_idle), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
